// File: rtl/ro_sensor_ctrl.sv
// Measurement sequencer for the NAND-gated ring-oscillator glitch sensor.
// Optional continuous back-to-back windows are enabled by defining RO_SENSOR_CONT_EN.
module ro_sensor_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WIN_W    = 16,
  parameter int WARM_CYC = 8
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thr_lo,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic             ro_out,
  input  logic             alarm_clr,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             alarm
);

  localparam int WARM_W = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_MEASURE,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         sync_q;
  logic               rise;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0]   win_sh_q, win_last;
  logic [CNT_W-1:0]   thr_lo_q, thr_hi_q;
  logic [CNT_W-1:0]   edge_q, edge_d, edge_inc;
  logic [CNT_W-1:0]   count_q;
  logic               alarm_q, alarm_d;
  logic               latch_cfg, enter_done, cont_go;
  logic               oob_new, oob_done;

  // sync_q[0] and sync_q[1] form the synchronizer; sync_q[2] is the edge-detect delay.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ro_out};
    end
  end

  assign rise     = sync_q[1] & ~sync_q[2];
  assign edge_inc = (rise && (edge_q != '1)) ? edge_q + CNT_W'(1) : edge_q;
  assign win_last = (win_sh_q == '0) ? '0 : win_sh_q - WIN_W'(1);
  assign oob_new  = (edge_inc < thr_lo_q) | (edge_inc > thr_hi_q);
  assign oob_done = (count_q < thr_lo_q) | (count_q > thr_hi_q);

`ifdef RO_SENSOR_CONT_EN
  assign cont_go = cont & ~stop;
`else
  // Continuous mode is compiled out; cont is read only to keep it connected.
  assign cont_go = cont & 1'b0;
`endif

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    win_cnt_d  = win_cnt_q;
    edge_d     = edge_q;
    latch_cfg  = 1'b0;
    enter_done = 1'b0;
    ro_en      = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d   = ST_WARMUP;
          latch_cfg = 1'b1;
          warm_d    = '0;
          win_cnt_d = '0;
          edge_d    = '0;
        end
      end
      ST_WARMUP: begin
        ro_en = 1'b1;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (warm_q == WARM_LAST) begin
          state_d   = ST_MEASURE;
          win_cnt_d = '0;
        end else begin
          warm_d = warm_q + WARM_W'(1);
        end
      end
      ST_MEASURE: begin
        ro_en  = 1'b1;
        edge_d = edge_inc;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (win_cnt_q == win_last) begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      ST_DONE: begin
        done  = 1'b1;
        ro_en = cont_go;
        if (cont_go) begin
          state_d   = ST_MEASURE;
          latch_cfg = 1'b1;
          win_cnt_d = '0;
          edge_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Alarm set in the DONE cycle beats a simultaneous clear.
  assign alarm_d = (enter_done & oob_new)
                 | ((state_q == ST_DONE) & oob_done)
                 | (alarm_q & ~alarm_clr);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q   <= ST_IDLE;
      warm_q    <= '0;
      win_cnt_q <= '0;
      edge_q    <= '0;
      win_sh_q  <= '0;
      thr_lo_q  <= '0;
      thr_hi_q  <= '0;
      count_q   <= '0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      win_cnt_q <= win_cnt_d;
      edge_q    <= edge_d;
      alarm_q   <= alarm_d;
      if (latch_cfg) begin
        win_sh_q <= win_len;
        thr_lo_q <= thr_lo;
        thr_hi_q <= thr_hi;
      end
      if (enter_done) begin
        count_q <= edge_inc;
      end
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign count = count_q;
  assign alarm = alarm_q;

endmodule

// File: tb/tb_ro_sensor_ctrl.sv
// Self-checking bench for ro_sensor_ctrl: a window-arithmetic reference model checked every
// cycle on two instances (16-bit and 4-bit counters), plus hand-computed directed checks.
module tb_ro_sensor_ctrl;

  localparam int WARM = 8;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, cont = 1'b0, alarm_clr = 1'b0, ro_out = 1'b0;
  logic [15:0] win_len = 16'd100, thr_lo = 16'd20, thr_hi = 16'd30;

  logic        ro_en, busy, done, alarm;
  logic [15:0] count;
  logic        ro_en4, busy4, done4, alarm4;
  logic [3:0]  count4;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int ro_half = 0, ro_ph = 0;
  int t;

  ro_sensor_ctrl #(.CNT_W(16), .WIN_W(16), .WARM_CYC(WARM)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .stop(stop), .cont(cont),
    .win_len(win_len), .thr_lo(thr_lo), .thr_hi(thr_hi), .ro_out(ro_out),
    .alarm_clr(alarm_clr), .ro_en(ro_en), .busy(busy), .done(done),
    .count(count), .alarm(alarm)
  );

  ro_sensor_ctrl #(.CNT_W(4), .WIN_W(16), .WARM_CYC(WARM)) dut4 (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .stop(stop), .cont(cont),
    .win_len(win_len), .thr_lo(thr_lo[3:0]), .thr_hi(thr_hi[3:0]), .ro_out(ro_out),
    .alarm_clr(alarm_clr), .ro_en(ro_en4), .busy(busy4), .done(done4),
    .count(count4), .alarm(alarm4)
  );

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  // Oscillator stand-in: toggles every ro_half mclk cycles, held low when ro_half is 0.
  always @(posedge mclk) begin
    #1;
    if (ro_half == 0) begin
      ro_out = 1'b0;
    end else begin
      ro_ph = ro_ph + 1;
      if (ro_ph >= ro_half) begin
        ro_ph  = 0;
        ro_out = ~ro_out;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a measurement is a span of cycle numbers; the count is the number
  // of rising edges of ro_out (seen through 3 cycles of input latency) inside that span.
  bit          v_hist [0:8191];
  bit          m_active = 1'b0;
  int          m_lo, m_hi, m_done_at;
  logic [15:0] m_tlo, m_thi;
  int          m_cnt16 = 0, m_cnt4 = 0;
  bit          m_oob16 = 1'b0, m_oob4 = 1'b0, carry16 = 1'b0, carry4 = 1'b0;

  always @(negedge mclk) begin : cmp
    int  k, s, n;
    bit  e_done, go, a16, a4;
    if (puc_rst) begin
      m_active = 1'b0;
      m_cnt16  = 0;
      m_cnt4   = 0;
      carry16  = 1'b0;
      carry4   = 1'b0;
    end else begin
      k = cyc;
      v_hist[k] = ro_out;
      e_done = m_active && (k == m_done_at);
`ifdef RO_SENSOR_CONT_EN
      go = cont && !stop;
`else
      go = 1'b0;
`endif
      if (e_done) begin
        s = 0;
        for (int m = m_lo; m <= m_hi; m++)
          if (m >= 3 && v_hist[m-2] && !v_hist[m-3]) s = s + 1;
        m_cnt16 = (s > 65535) ? 65535 : s;
        m_cnt4  = (s > 15) ? 15 : s;
        m_oob16 = (m_cnt16 < m_tlo) || (m_cnt16 > m_thi);
        m_oob4  = (m_cnt4 < m_tlo[3:0]) || (m_cnt4 > m_thi[3:0]);
      end
      a16 = carry16 || (e_done && m_oob16);
      a4  = carry4 || (e_done && m_oob4);
      check("m_busy", busy, m_active);
      check("m_ro_en", ro_en, m_active && ((k < m_done_at) || (e_done && go)));
      check("m_done", done, e_done);
      check("m_count", count, m_cnt16);
      check("m_alarm", alarm, a16);
      check("m_done4", done4, e_done);
      check("m_count4", count4, m_cnt4);
      check("m_alarm4", alarm4, a4);
      carry16 = (a16 && !alarm_clr) || (e_done && m_oob16);
      carry4  = (a4 && !alarm_clr) || (e_done && m_oob4);
      n = (win_len == 16'd0) ? 1 : int'(win_len);
      if (!m_active) begin
        if (start && !stop) begin
          m_active  = 1'b1;
          m_lo      = k + WARM + 1;
          m_hi      = k + WARM + n;
          m_done_at = m_hi + 1;
          m_tlo     = thr_lo;
          m_thi     = thr_hi;
        end
      end else if (e_done) begin
        if (go) begin
          m_lo      = k + 1;
          m_hi      = k + n;
          m_done_at = m_hi + 1;
          m_tlo     = thr_lo;
          m_thi     = thr_hi;
        end else begin
          m_active = 1'b0;
        end
      end else if (stop) begin
        m_active = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic run_start(output int ts);
    start = 1'b1;
    ts    = cyc;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset, then idle.
    step(3);
    puc_rst = 1'b0;
    step(20);
    @(negedge mclk);
    check("rst_busy", busy, 0);
    check("rst_ro_en", ro_en, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_alarm", alarm, 0);

    // Period-4 oscillator, 100-cycle window: 25 edges, in band.
    ro_half = 2;
    step(5);
    run_start(t);
    @(negedge mclk);
    check("warm_ro_en", ro_en, 1);
    step(107);
    @(negedge mclk);
    check("p4_not_done_early", done, 0);
    step(1);
    @(negedge mclk);
    check("p4_done_t109", done, 1);
    check("p4_count", count, 25);
    check("p4_alarm", alarm, 0);
    step(1);
    @(negedge mclk);
    check("p4_busy_low_t110", busy, 0);

    // Stop mid-measurement together with start: back to IDLE, count untouched.
    run_start(t);
    step(58);
    stop  = 1'b1;
    start = 1'b1;
    step(1);
    stop  = 1'b0;
    start = 1'b0;
    @(negedge mclk);
    check("stop_busy", busy, 0);
    check("stop_ro_en", ro_en, 0);
    step(120);
    @(negedge mclk);
    check("stop_count_kept", count, 25);
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    @(negedge mclk);
    check("idle_stop_beats_start", busy, 0);

    // Zero window length behaves as one cycle.
    win_len = 16'd0;
    thr_lo  = 16'd0;
    thr_hi  = 16'hffff;
    run_start(t);
    step(8);
    @(negedge mclk);
    check("win0_measuring", busy, 1);
    check("win0_not_done", done, 0);
    step(1);
    @(negedge mclk);
    check("win0_done_t10", done, 1);
    step(2);
    win_len = 16'd100;
    thr_lo  = 16'd20;
    thr_hi  = 16'd30;

    // Period-8 oscillator: 12 or 13 edges, alarm; clear held in DONE does not win.
    ro_half = 4;
    step(3);
    run_start(t);
    step(108);
    alarm_clr = 1'b1;
    @(negedge mclk);
    check("p8_done", done, 1);
    check("p8_count_12_13", (count == 16'd12) || (count == 16'd13), 1);
    check("p8_alarm", alarm, 1);
    step(1);
    @(negedge mclk);
    check("p8_alarm_set_wins", alarm, 1);
    step(1);
    alarm_clr = 1'b0;
    @(negedge mclk);
    check("p8_alarm_cleared", alarm, 0);

    // Edge every 2 cycles: 50 edges, the 4-bit counter saturates at 15.
    ro_half = 1;
    thr_lo  = 16'd0;
    thr_hi  = 16'd14;
    run_start(t);
    step(108);
    @(negedge mclk);
    check("sat_done", done4, 1);
    check("sat_count16", count, 50);
    check("sat_count4", count4, 15);
    check("sat_alarm4", alarm4, 1);
    step(2);

`ifdef RO_SENSOR_CONT_EN
    // Continuous mode: done every 11 cycles, then one more after cont drops.
    ro_half = 2;
    win_len = 16'd10;
    thr_hi  = 16'hffff;
    cont    = 1'b1;
    run_start(t);
    step(18);
    @(negedge mclk);
    check("cont_done1", done, 1);
    check("cont_ro_en1", ro_en, 1);
    step(11);
    @(negedge mclk);
    check("cont_done2", done, 1);
    step(11);
    @(negedge mclk);
    check("cont_done3", done, 1);
    step(1);
    cont = 1'b0;
    step(10);
    @(negedge mclk);
    check("cont_last_done", done, 1);
    check("cont_last_ro_en", ro_en, 0);
    step(1);
    @(negedge mclk);
    check("cont_idle", busy, 0);
    win_len = 16'd100;
`endif

    // Asynchronous reset mid-measurement clears everything at once.
    ro_half = 4;
    thr_lo  = 16'd20;
    thr_hi  = 16'd30;
    run_start(t);
    step(30);
    #2;
    puc_rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ro_en", ro_en, 0);
    check("arst_count", count, 0);
    check("arst_alarm", alarm4, 0);
    step(2);
    puc_rst = 1'b0;
    step(3);
    @(negedge mclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ro_sensor_ctrl.md
# ro_sensor_ctrl

Measurement sequencer for the NAND-gated ring-oscillator glitch sensor in the MSP430 peripheral space. It enables the oscillator through its NAND enable leg, lets it settle, and counts rising edges of the divided oscillator output over a programmable window of `mclk` cycles. It publishes the count and raises a sticky alarm when the count falls outside a programmed band, which indicates a voltage or clock glitch.

## Interface
Parameters:
- `CNT_W`, 16: edge-counter and threshold width.
- `WIN_W`, 16: window-length width.
- `WARM_CYC`, 8: settle cycles before counting (≥3; covers synchronizer flush).

Ports:
- `mclk` in 1: the single clock for the block.
- `puc_rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a measurement when idle.
- `stop` in 1: aborts a measurement in progress.
- `cont` in 1: continuous-mode request (effective only with the macro below).
- `win_len` in WIN_W: window length in `mclk` cycles.
- `thr_lo`, `thr_hi` in CNT_W: inclusive pass band.
- `ro_out` in 1: divided oscillator output, asynchronous to `mclk`, with ≤ `mclk`/2 toggle rate.
- `alarm_clr` in 1: clears `alarm`.
- `ro_en` out 1: drives the NAND enable leg of the oscillator.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse; `count` is valid.
- `count` out CNT_W: last completed measurement.
- `alarm` out 1: sticky out-of-band flag.

## Operation
- `ro_out` passes through a 2-flop synchronizer plus a third flop. A rising edge is `sync2 & ~sync3`.
- States:
  - IDLE: `ro_en`=0. On `start`, latch `win_len`, `thr_lo` and `thr_hi` into shadow registers, clear the window and edge counters, go to WARMUP.
  - WARMUP: `ro_en`=1. Counts `WARM_CYC` cycles with no edge counting, then goes to MEASURE.
  - MEASURE: `ro_en`=1. Each cycle the edge counter increments on a detected rising edge and saturates at all-ones. Leaves after `win_len` cycles; a shadowed `win_len`=0 is treated as 1.
  - DONE: assert `done` for one cycle and load `count` ← edge counter. Set `alarm` if `count` < `thr_lo` or `count` > `thr_hi`. Next state is IDLE, or MEASURE in continuous mode.
- `start` while `busy` is ignored.
- `stop`:
  - In WARMUP or MEASURE: next state is IDLE, `ro_en` drops next cycle, no `done`, `count` and `alarm` unchanged.
  - In DONE: the DONE cycle completes normally, then the block goes to IDLE even in continuous mode.
- `stop` has priority over `start` in the same cycle.
- If `alarm_clr` and an alarm set occur in the same cycle, the set wins.
- If `thr_lo` > `thr_hi`, every measurement alarms. No special case.

## Timing
- Reset values: `ro_en`=0, `busy`=0, `done`=0, `count`=0, `alarm`=0, state IDLE, synchronizer flops 0. Reset mid-measurement returns to IDLE immediately and asynchronously.
- For `start` sampled in cycle t:
  - WARMUP and `ro_en`=1 cover cycles t+1 … t+`WARM_CYC`.
  - MEASURE covers cycles t+`WARM_CYC`+1 … t+`WARM_CYC`+N, where N is the effective `win_len`.
  - DONE is cycle t+`WARM_CYC`+N+1, with `done`, `count` and `alarm` updated that cycle.
  - `busy` falls at t+`WARM_CYC`+N+2.
- `ro_en` is 0 in DONE unless continuous mode will re-enter MEASURE, in which case it stays 1.
- Edges are attributed to the cycle in which `sync2 & ~sync3` is seen (3-cycle input latency). Because WARMUP flushes the synchronizer, only edges arriving after enable are counted.
- `alarm` rises in the DONE cycle and stays high until `alarm_clr`. It clears one cycle after `alarm_clr` is sampled.

## Configuration
- `RO_SENSOR_CONT_EN` defined:
  - When `cont`=1 in DONE, the next state is MEASURE. Shadow thresholds and `win_len` re-latch from the inputs and the edge counter clears.
  - There is no WARMUP between windows, and `ro_en` stays high continuously.
  - `done` pulses once per window.
- `RO_SENSOR_CONT_EN` undefined: `cont` is ignored and DONE always goes to IDLE.

## Test plan
- Reset, then idle 20 cycles → all outputs 0, `ro_en`=0.
- `ro_out` period 4 `mclk`, `WARM_CYC`=8, `win_len`=100, `thr_lo`=20, `thr_hi`=30, `start` at cycle t → `done` at t+109, `count`=25, `alarm`=0, `busy` low at t+110.
- Same stimulus with `ro_out` period 8 → `count`=12 or 13 depending on phase, `alarm`=1. Hold `alarm_clr` high in the DONE cycle → `alarm` still 1. `alarm_clr` one cycle later → `alarm`=0 the following cycle.
- `stop` 50 cycles into MEASURE → IDLE next cycle, `ro_en`=0, no `done`, `count` keeps its previous value. `start` in the same cycle as `stop` is ignored.
- `ro_out` toggling every cycle (rising edge every 2 `mclk`), `CNT_W`=4, `win_len`=100 → `count`=15 (saturated), `alarm` set when `thr_hi`=14.
- With `RO_SENSOR_CONT_EN` and `cont`=1, `win_len`=10 → `done` every 11 cycles after the first, `ro_en` never drops. Deassert `cont` → exactly one more `done`, then IDLE.
